// File: rtl/ingreso_datos_param.sv
// ingreso_datos_param
// Push-button data entry for a clock, a calendar date and a countdown timer.
// Nine fields are kept as binary registers and shown as packed BCD.
// A held increment or decrement button auto-repeats. Days are limited by the
// month and by leap years. The clock hour can be shown in 12 h form with a PM flag.
//
// Parameters
//   REP_DELAY  : cycles a button must stay held after the first step before the
//                first repeat step (>= 2)
//   REP_PERIOD : cycles between later repeat steps (>= 1)
//   CW         : repeat counter width; must hold max(REP_DELAY, REP_PERIOD)
//
// Ports
//   clk, reset       : clock (rising edge), asynchronous active-low reset
//   C_T              : 1 = clock+date bank (6 fields), 0 = timer bank (3 fields)
//   escribe          : edit enable
//   aumenta/disminuye: increment / decrement buttons (levels)
//   corre_der/izq    : cursor right / left buttons (levels, edge detected)
//   doce_24          : 1 = 12 h display of hora_C
//   seg_C..hora_T    : packed BCD field values
//   pm_C             : PM flag (only when doce_24 = 1)
//   campo            : cursor index
//   carga            : one-cycle strobe after any stored field changed
module ingreso_datos_param #(
    parameter int REP_DELAY  = 16,
    parameter int REP_PERIOD = 4,
    parameter int CW         = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       C_T,
    input  logic       escribe,
    input  logic       aumenta,
    input  logic       disminuye,
    input  logic       corre_der,
    input  logic       corre_izq,
    input  logic       doce_24,
    output logic [7:0] seg_C,
    output logic [7:0] min_C,
    output logic [7:0] hora_C,
    output logic [7:0] dia,
    output logic [7:0] mes,
    output logic [7:0] ano,
    output logic [7:0] seg_T,
    output logic [7:0] min_T,
    output logic [7:0] hora_T,
    output logic       pm_C,
    output logic [2:0] campo,
    output logic       carga
);

    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};

    // Step one position inside [lo, hi], wrapping at both ends.
    function automatic logic [6:0] step_wrap(input logic [6:0] v, input logic [6:0] lo,
                                             input logic [6:0] hi, input logic up);
        if (up) begin
            return (v >= hi) ? lo : v + 7'd1;
        end else begin
            return (v <= lo) ? hi : v - 7'd1;
        end
    endfunction

    // Last day of a month; every year 2000-2099 divisible by 4 is a leap year.
    function automatic logic [6:0] days_in(input logic [6:0] mon, input logic [6:0] yr);
        case (mon)
            7'd2:                         return (yr[1:0] == 2'b00) ? 7'd29 : 7'd28;
            7'd4, 7'd6, 7'd9, 7'd11:      return 7'd30;
            default:                      return 7'd31;
        endcase
    endfunction

    function automatic logic [7:0] to_bcd(input logic [6:0] v);
        logic [7:0] w;
        w = {1'b0, v};
        return ((w / 8'd10) << 4) | (w % 8'd10);
    endfunction

    logic [6:0] sec_c_q, min_c_q, hr_c_q, day_q, mon_q, yr_q, sec_t_q, min_t_q, hr_t_q;
    logic [6:0] sec_c_d, min_c_d, hr_c_d, day_d, mon_d, yr_d, sec_t_d, min_t_d, hr_t_d;
    logic [6:0] day_s, dmax_new_s, disp_hr_s;
    logic [2:0] campo_q, campo_d, last_s;
    logic       carga_q, carga_d;
    logic       aum_q, dis_q, der_q, izq_q, esc_q, ct_q, arm_q;
    logic [CW-1:0] cnt_q, cnt_d, thr_s;
    logic       rep_q, rep_d;
    logic       inc_only_s, dec_only_s, press_s, der_p_s, izq_p_s, cur_press_s;
    logic       ct_chg_s, esc_fall_s, step_s, step_ok_s;

    // arm_q is low only on the first edge after reset, so a button that is
    // already held when reset is released does not count as a press.
    assign inc_only_s  = aumenta & ~disminuye;
    assign dec_only_s  = disminuye & ~aumenta;
    assign press_s     = arm_q & ((inc_only_s & ~aum_q) | (dec_only_s & ~dis_q));
    assign der_p_s     = arm_q & corre_der & ~der_q;
    assign izq_p_s     = arm_q & corre_izq & ~izq_q;
    assign cur_press_s = der_p_s | izq_p_s;
    assign ct_chg_s    = C_T ^ ct_q;
    assign esc_fall_s  = esc_q & ~escribe;
    assign thr_s       = rep_q ? CW'(REP_PERIOD) : CW'(REP_DELAY);
    assign last_s      = C_T ? 3'd5 : 3'd2;
    assign step_ok_s   = step_s & ~cur_press_s & ~ct_chg_s;

    // Auto-repeat timing: cnt_q = cycles since the press or the last repeat step; 0 = idle.
    always_comb begin
        cnt_d  = cnt_q;
        rep_d  = rep_q;
        step_s = 1'b0;
        if (!escribe || !(inc_only_s || dec_only_s)) begin
            cnt_d = CNT_ZERO;
            rep_d = 1'b0;
        end else if (press_s) begin
            cnt_d  = CNT_ONE;
            rep_d  = 1'b0;
            step_s = 1'b1;
        end else if (cnt_q == CNT_ZERO) begin
            cnt_d = CNT_ZERO;
        end else if (cnt_q == thr_s) begin
            cnt_d  = CNT_ONE;
            rep_d  = 1'b1;
            step_s = 1'b1;
        end else begin
            cnt_d = cnt_q + CNT_ONE;
        end
    end

    // Cursor movement and return to field 0.
    always_comb begin
        campo_d = campo_q;
        if (ct_chg_s || esc_fall_s) begin
            campo_d = 3'd0;
        end else if (escribe && der_p_s && !izq_p_s) begin
            campo_d = (campo_q >= last_s) ? 3'd0 : campo_q + 3'd1;
        end else if (escribe && izq_p_s && !der_p_s) begin
            campo_d = (campo_q == 3'd0 || campo_q > last_s) ? last_s : campo_q - 3'd1;
        end else begin
            campo_d = campo_q;
        end
    end

    // Field update. Any month or year change clamps the day to the new month length.
    always_comb begin
        sec_c_d = sec_c_q;
        min_c_d = min_c_q;
        hr_c_d  = hr_c_q;
        mon_d   = mon_q;
        yr_d    = yr_q;
        sec_t_d = sec_t_q;
        min_t_d = min_t_q;
        hr_t_d  = hr_t_q;
        day_s   = day_q;
        if (step_ok_s) begin
            if (C_T) begin
                case (campo_q)
                    3'd0:    sec_c_d = step_wrap(sec_c_q, 7'd0, 7'd59, inc_only_s);
                    3'd1:    min_c_d = step_wrap(min_c_q, 7'd0, 7'd59, inc_only_s);
                    3'd2:    hr_c_d  = step_wrap(hr_c_q, 7'd0, 7'd23, inc_only_s);
                    3'd3:    day_s   = step_wrap(day_q, 7'd1, days_in(mon_q, yr_q), inc_only_s);
                    3'd4:    mon_d   = step_wrap(mon_q, 7'd1, 7'd12, inc_only_s);
                    3'd5:    yr_d    = step_wrap(yr_q, 7'd0, 7'd99, inc_only_s);
                    default: sec_c_d = sec_c_q;
                endcase
            end else begin
                case (campo_q)
                    3'd0:    sec_t_d = step_wrap(sec_t_q, 7'd0, 7'd59, inc_only_s);
                    3'd1:    min_t_d = step_wrap(min_t_q, 7'd0, 7'd59, inc_only_s);
                    3'd2:    hr_t_d  = step_wrap(hr_t_q, 7'd0, 7'd23, inc_only_s);
                    default: sec_t_d = sec_t_q;
                endcase
            end
        end else begin
            day_s = day_q;
        end
        dmax_new_s = days_in(mon_d, yr_d);
        day_d      = (day_s > dmax_new_s) ? dmax_new_s : day_s;
        carga_d    = (sec_c_d != sec_c_q) | (min_c_d != min_c_q) | (hr_c_d != hr_c_q) |
                     (day_d != day_q) | (mon_d != mon_q) | (yr_d != yr_q) |
                     (sec_t_d != sec_t_q) | (min_t_d != min_t_q) | (hr_t_d != hr_t_q);
    end

    // State registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sec_c_q <= 7'd0;
            min_c_q <= 7'd0;
            hr_c_q  <= 7'd0;
            day_q   <= 7'd1;
            mon_q   <= 7'd1;
            yr_q    <= 7'd0;
            sec_t_q <= 7'd0;
            min_t_q <= 7'd0;
            hr_t_q  <= 7'd0;
            campo_q <= 3'd0;
            carga_q <= 1'b0;
            aum_q   <= 1'b0;
            dis_q   <= 1'b0;
            der_q   <= 1'b0;
            izq_q   <= 1'b0;
            esc_q   <= 1'b0;
            ct_q    <= 1'b1;
            arm_q   <= 1'b0;
            cnt_q   <= CNT_ZERO;
            rep_q   <= 1'b0;
        end else begin
            sec_c_q <= sec_c_d;
            min_c_q <= min_c_d;
            hr_c_q  <= hr_c_d;
            day_q   <= day_d;
            mon_q   <= mon_d;
            yr_q    <= yr_d;
            sec_t_q <= sec_t_d;
            min_t_q <= min_t_d;
            hr_t_q  <= hr_t_d;
            campo_q <= campo_d;
            carga_q <= carga_d;
            aum_q   <= aumenta;
            dis_q   <= disminuye;
            der_q   <= corre_der;
            izq_q   <= corre_izq;
            esc_q   <= escribe;
            ct_q    <= C_T;
            arm_q   <= 1'b1;
            cnt_q   <= cnt_d;
            rep_q   <= rep_d;
        end
    end

    // Displayed clock hour: the stored value is always 24 h.
    always_comb begin
        if (!doce_24) begin
            disp_hr_s = hr_c_q;
        end else if (hr_c_q == 7'd0) begin
            disp_hr_s = 7'd12;
        end else if (hr_c_q > 7'd12) begin
            disp_hr_s = hr_c_q - 7'd12;
        end else begin
            disp_hr_s = hr_c_q;
        end
    end

    assign seg_C  = to_bcd(sec_c_q);
    assign min_C  = to_bcd(min_c_q);
    assign hora_C = to_bcd(disp_hr_s);
    assign dia    = to_bcd(day_q);
    assign mes    = to_bcd(mon_q);
    assign ano    = to_bcd(yr_q);
    assign seg_T  = to_bcd(sec_t_q);
    assign min_T  = to_bcd(min_t_q);
    assign hora_T = to_bcd(hr_t_q);
    assign pm_C   = doce_24 & (hr_c_q >= 7'd12);
    assign campo  = campo_q;
    assign carga  = carga_q;

endmodule

// File: tb/tb_ingreso_datos_param.sv
// Testbench for ingreso_datos_param: directed sequences followed by random
// button activity, scored against a cycle-level reference model.
module tb_ingreso_datos_param;
    localparam int RD = 16;
    localparam int RP = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset, C_T, escribe, aumenta, disminuye, corre_der, corre_izq, doce_24;
    logic [7:0] seg_C, min_C, hora_C, dia, mes, ano, seg_T, min_T, hora_T;
    logic pm_C, carga;
    logic [2:0] campo;

    ingreso_datos_param #(.REP_DELAY(RD), .REP_PERIOD(RP), .CW(8)) dut (
        .clk(clk), .reset(reset), .C_T(C_T), .escribe(escribe), .aumenta(aumenta),
        .disminuye(disminuye), .corre_der(corre_der), .corre_izq(corre_izq),
        .doce_24(doce_24), .seg_C(seg_C), .min_C(min_C), .hora_C(hora_C), .dia(dia),
        .mes(mes), .ano(ano), .seg_T(seg_T), .min_T(min_T), .hora_T(hora_T),
        .pm_C(pm_C), .campo(campo), .carga(carga)
    );

    int n_chk = 0;
    int n_pass = 0;

    // Reference state: 0 sec,1 min,2 hour (24 h),3 day,4 month,5 year,6..8 timer s/m/h
    int m_f[9];
    int m_campo;
    int hold_t;
    bit p_aum, p_dis, p_der, p_izq, p_esc, p_ct;
    logic [72:0] exp_q[$];

    task automatic chk(input string name, input logic [72:0] act, input logic [72:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    function automatic int days_in(input int m, input int y);
        if (m == 2) return (y % 4 == 0) ? 29 : 28;
        if (m == 4 || m == 6 || m == 9 || m == 11) return 30;
        return 31;
    endfunction

    function automatic logic [7:0] bcd(input int v);
        return 8'((v / 10) * 16 + v % 10);
    endfunction

    function automatic logic [72:0] snap();
        int h, dh;
        h = m_f[2];
        dh = doce_24 ? ((h % 12 == 0) ? 12 : h % 12) : h;
        return {bcd(m_f[0]), bcd(m_f[1]), bcd(dh), bcd(m_f[3]), bcd(m_f[4]), bcd(m_f[5]),
                bcd(m_f[6]), bcd(m_f[7]), bcd(m_f[8]), (doce_24 && h >= 12)};
    endfunction

    function automatic void model_reset();
        m_f = '{0, 0, 0, 1, 1, 0, 0, 0, 0};
        m_campo = 0;
        hold_t = -1;
        // Buttons held across reset must be released before they count again.
        p_aum = 1'b1; p_dis = 1'b1; p_der = 1'b1; p_izq = 1'b1;
        p_esc = 1'b0; p_ct = C_T;
    endfunction

    task automatic model_step();
        bit up, dn, pressed, cp, dp, ip, ctc, ef, step, changed;
        int old_f[9];
        int idx, lo, hi, n, last;
        old_f = m_f;
        up = aumenta && !disminuye;
        dn = disminuye && !aumenta;
        pressed = (up && !p_aum) || (dn && !p_dis);
        dp = corre_der && !p_der;
        ip = corre_izq && !p_izq;
        cp = dp || ip;
        ctc = (C_T != p_ct);
        ef = p_esc && !escribe;
        step = 1'b0;
        if (!escribe || !(up || dn)) hold_t = -1;
        else if (pressed) begin hold_t = 0; step = 1'b1; end
        else if (hold_t >= 0) begin
            hold_t++;
            step = (hold_t >= RD) && ((hold_t - RD) % RP == 0);
        end
        if (step && !cp && !ctc) begin
            idx = C_T ? m_campo : m_campo + 6;
            case (idx)
                2, 8:    begin lo = 0; hi = 23; end
                3:       begin lo = 1; hi = days_in(m_f[4], m_f[5]); end
                4:       begin lo = 1; hi = 12; end
                5:       begin lo = 0; hi = 99; end
                default: begin lo = 0; hi = 59; end
            endcase
            n = hi - lo + 1;
            m_f[idx] = lo + ((m_f[idx] - lo + (up ? 1 : -1) + n) % n);
            if (m_f[3] > days_in(m_f[4], m_f[5])) m_f[3] = days_in(m_f[4], m_f[5]);
        end
        last = C_T ? 5 : 2;
        if (ctc || ef) m_campo = 0;
        else if (escribe && dp && !ip) m_campo = (m_campo == last) ? 0 : m_campo + 1;
        else if (escribe && ip && !dp) m_campo = (m_campo == 0) ? last : m_campo - 1;
        p_aum = aumenta; p_dis = disminuye; p_der = corre_der; p_izq = corre_izq;
        p_esc = escribe; p_ct = C_T;
        changed = 1'b0;
        for (int i = 0; i < 9; i++) if (m_f[i] != old_f[i]) changed = 1'b1;
        if (changed) exp_q.push_back(snap());
    endtask

    // One clock: model follows the edge; returns shortly after the falling edge.
    task automatic cycle();
        @(posedge clk);
        if (reset) model_step();
        @(negedge clk);
        #2;
    endtask

    task automatic set_btn(input int which, input logic v);
        case (which)
            0: aumenta = v;
            1: disminuye = v;
            2: corre_der = v;
            default: corre_izq = v;
        endcase
    endtask

    task automatic pulse(input int which);
        set_btn(which, 1'b1);
        cycle();
        set_btn(which, 1'b0);
        cycle();
    endtask

    task automatic do_reset(input int k);
        chk("pending_carga", 73'(exp_q.size()), 73'd0);
        exp_q.delete();
        reset = 1'b0;
        model_reset();
        repeat (k) cycle();
        reset = 1'b1;
    endtask

    // Monitor: cursor and displayed hour every cycle; field snapshot on every carga.
    initial begin
        logic [72:0] e, a;
        forever begin
            @(negedge clk);
            #1;
            e = snap();
            chk("campo", 73'(campo), 73'(m_campo));
            chk("hora_disp", 73'({hora_C, pm_C}), 73'({e[56:49], e[0]}));
            if (carga === 1'b1) begin
                if (exp_q.size() == 0) begin
                    chk("carga_unexpected", 73'(carga), 73'd0);
                end else begin
                    e = exp_q.pop_front();
                    a = {seg_C, min_C, hora_C, dia, mes, ano, seg_T, min_T, hora_T, pm_C};
                    chk("fields", a, e);
                end
            end
        end
    end

    initial begin
        reset = 1'b0; C_T = 1'b1; escribe = 1'b0; aumenta = 1'b0; disminuye = 1'b0;
        corre_der = 1'b0; corre_izq = 1'b0; doce_24 = 1'b0;
        model_reset();
        repeat (3) cycle();
        chk("rst_seg_C", 73'(seg_C), 73'h00);
        chk("rst_hora_C", 73'(hora_C), 73'h00);
        chk("rst_dia", 73'(dia), 73'h01);
        chk("rst_mes", 73'(mes), 73'h01);
        chk("rst_ano", 73'(ano), 73'h00);
        chk("rst_timer", 73'({seg_T, min_T, hora_T}), 73'h0);
        chk("rst_carga", 73'(carga), 73'd0);
        reset = 1'b1;
        escribe = 1'b1;
        cycle();

        // Single decrement wraps seconds; carga is a single-cycle pulse.
        disminuye = 1'b1;
        cycle();
        chk("tp2_carga_hi", 73'(carga), 73'd1);
        chk("tp2_seg59", 73'(seg_C), 73'h59);
        disminuye = 1'b0;
        cycle();
        chk("tp2_carga_lo", 73'(carga), 73'd0);
        pulse(0);
        chk("tp2_seg00", 73'(seg_C), 73'h00);

        // Auto-repeat: steps at t = 0, 16, 20, 24, 28.
        aumenta = 1'b1;
        repeat (RD + 3 * RP + 1) cycle();
        aumenta = 1'b0;
        cycle();
        chk("tp3_repeat", 73'(seg_C), 73'h05);
        aumenta = 1'b1; disminuye = 1'b1;
        repeat (25) cycle();
        aumenta = 1'b0; disminuye = 1'b0;
        cycle();
        chk("tp3_both", 73'(seg_C), 73'h05);

        // 12 h display.
        doce_24 = 1'b1;
        pulse(2);
        pulse(2);
        chk("tp4_h12", 73'({hora_C, pm_C}), 73'({8'h12, 1'b0}));
        pulse(1);
        chk("tp4_h11pm", 73'({hora_C, pm_C}), 73'({8'h11, 1'b1}));
        doce_24 = 1'b0;
        cycle();
        chk("tp4_h23", 73'({hora_C, pm_C}), 73'({8'h23, 1'b0}));

        // Day clamp on month and year change.
        pulse(2);
        pulse(1);
        chk("tp5_dia31", 73'(dia), 73'h31);
        pulse(2);
        pulse(0);
        chk("tp5_feb", 73'({mes, dia}), 73'h0229);
        pulse(2);
        pulse(0);
        chk("tp5_y01", 73'({ano, dia}), 73'h0128);

        // Timer bank cursor wrap and gating.
        C_T = 1'b0;
        cycle();
        chk("tp6_ct0", 73'(campo), 73'd0);
        pulse(3);
        chk("tp6_izq_wrap", 73'(campo), 73'd2);
        pulse(2);
        chk("tp6_der_wrap", 73'(campo), 73'd0);
        pulse(2);
        C_T = 1'b1;
        cycle();
        C_T = 1'b0;
        cycle();
        chk("tp6_toggle", 73'(campo), 73'd0);
        escribe = 1'b0;
        cycle();
        pulse(0);
        chk("tp6_gated", 73'(seg_T), 73'h00);
        escribe = 1'b1;
        aumenta = 1'b1;
        repeat (5) cycle();
        chk("tp6_hold", 73'(seg_T), 73'h01);
        do_reset(2);
        repeat (RD + 4) cycle();
        chk("tp6_after_rst", 73'({seg_T, seg_C, dia}), 73'h000001);
        aumenta = 1'b0;
        cycle();
        pulse(0);
        chk("tp6_repress", 73'(seg_T), 73'h01);

        // Random activity.
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 9) == 0) aumenta = ~aumenta;
            if ($urandom_range(0, 15) == 0) disminuye = ~disminuye;
            corre_der = ($urandom_range(0, 11) == 0);
            corre_izq = ($urandom_range(0, 13) == 0);
            if ($urandom_range(0, 59) == 0) C_T = ~C_T;
            escribe = escribe ? ($urandom_range(0, 39) != 0) : ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 29) == 0) doce_24 = ~doce_24;
            if ($urandom_range(0, 399) == 0) begin
                do_reset(2);
            end else begin
                cycle();
            end
        end
        aumenta = 1'b0; disminuye = 1'b0; corre_der = 1'b0; corre_izq = 1'b0;
        repeat (3) cycle();
        chk("queue_drained", 73'(exp_q.size()), 73'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
